// File: rtl/prom_programmer.sv
// prom_programmer: write-side sequencer for blank-to-1 fuse PROMs.
// One target word per address; missing bits fused lowest-first, then re-read.
module prom_programmer #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 5,
  parameter int PULSE  = 10,
  parameter int RETRY  = 3
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [HEIGHT-1:0] err_addr,
  output logic [HEIGHT-1:0] dev_a,
  output logic [WIDTH-1:0]  dev_d,
  output logic              dev_pgm,
  output logic              dev_cs_,
  input  logic [WIDTH-1:0]  dev_q
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(RETRY + 1);
  localparam int PW = (PULSE > 1) ? $clog2(PULSE) : 1;
  localparam logic [CW-1:0]     RETRY_C = CW'(RETRY);
  localparam logic [PW-1:0]     PLAST   = PW'(PULSE - 1);
  localparam logic [HEIGHT-1:0] ALAST   = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_RD0, S_RD1, S_CMP,
    S_PULSE, S_GAP, S_DONE, S_FAIL
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  tgt_q;
  logic [WIDTH-1:0]  cur_q;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     sel_q;
  logic [PW-1:0]     pcnt_q;
  logic              first_q;
  logic              wr_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [HEIGHT-1:0] err_addr_q;
  logic [HEIGHT-1:0] dev_a_q;
  logic [WIDTH-1:0]  dev_d_q;
  logic              dev_pgm_q;
  logic              dev_cs_n_q;

  logic [WIDTH-1:0]  miss_d;
  logic              bad_d;
  logic [SW-1:0]     idx_d;
  logic              newbit_d;
  logic [CW-1:0]     cnt_eff_d;

  // Compare read-back against target; pick the lowest still-blank bit.
  always_comb begin
    miss_d = tgt_q & ~cur_q;
    bad_d  = |(cur_q & ~tgt_q);
    idx_d  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (miss_d[i]) idx_d = SW'(i);
    end
    newbit_d  = first_q || (idx_d != sel_q);
    cnt_eff_d = newbit_d ? '0 : cnt_q;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      pcnt_q     <= '0;
      first_q    <= 1'b0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      dev_a_q    <= '0;
      dev_d_q    <= '0;
      dev_pgm_q  <= 1'b0;
      dev_cs_n_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            dev_a_q    <= '0;
            wr_ready_q <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wr_valid) begin
            tgt_q      <= wr_data;
            first_q    <= 1'b1;
            wr_ready_q <= 1'b0;
            dev_cs_n_q <= 1'b0;
            state_q    <= S_RD0;
          end
        end
        S_RD0: state_q <= S_RD1;
        S_RD1: begin
          cur_q      <= dev_q;
          dev_cs_n_q <= 1'b1;
          state_q    <= S_CMP;
        end
        S_CMP: begin
          if (bad_d) begin
            err_q      <= 1'b1;
            err_addr_q <= dev_a_q;
            busy_q     <= 1'b0;
            state_q    <= S_FAIL;
          end else if (miss_d == '0) begin
            if (dev_a_q == ALAST) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              dev_a_q    <= dev_a_q + HEIGHT'(1);
              wr_ready_q <= 1'b1;
              state_q    <= S_WAIT;
            end
          end else begin
            sel_q <= idx_d;
            if (cnt_eff_d == RETRY_C) begin
              cnt_q      <= cnt_eff_d;
              err_q      <= 1'b1;
              err_addr_q <= dev_a_q;
              busy_q     <= 1'b0;
              state_q    <= S_FAIL;
            end else begin
              cnt_q     <= cnt_eff_d + CW'(1);
              first_q   <= 1'b0;
              pcnt_q    <= '0;
              dev_pgm_q <= 1'b1;
              dev_d_q   <= WIDTH'(1) << idx_d;
              state_q   <= S_PULSE;
            end
          end
        end
        S_PULSE: begin
          if (pcnt_q == PLAST) begin
            dev_pgm_q <= 1'b0;
            dev_d_q   <= '0;
            state_q   <= S_GAP;
          end else begin
            pcnt_q <= pcnt_q + PW'(1);
          end
        end
        S_GAP: begin
          dev_cs_n_q <= 1'b0;
          state_q    <= S_RD0;
        end
        S_DONE: state_q <= S_IDLE;
        S_FAIL: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign dev_a    = dev_a_q;
  assign dev_d    = dev_d_q;
  assign dev_pgm  = dev_pgm_q;
  assign dev_cs_  = dev_cs_n_q;

endmodule
